mitch_log_mult_pipe: RTL
========================

// Module: mitch_log_mult_pipe
// PURPOSE
//  Parametrised, pipelined Mitchell-style approximate logarithmic multiplier with
//  operand-fraction truncation to W bits. Unsigned NxN -> 2N product. Valid/ready
//  streaming on both sides with backpressure. Successor to the fixed 16-bit,
//  single-register-stage multiplier wrapper.
// PARAMETERS
//  N  16  operand width in bits (N >= 4)
//  W   6  fraction bits kept after leading-one normalisation (1 <= W <= N-1)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  in_valid   in   1   x/y carry an operand pair
//  in_ready   out  1   block accepts the pair this cycle
//  x          in   N   operand A, unsigned
//  y          in   N   operand B, unsigned
//  out_valid  out  1   p holds a result
//  out_ready  in   1   downstream accepts p this cycle
//  p          out  2N  approximate product, unsigned
// BEHAVIOUR
//  Arithmetic:
//  - k = index of the leading one. F = bits below the leading one, left-aligned to N-1 bits.
//    Keep the top W bits as f (value f/2^W).
//  - S = fx + fy, W+1 bits.
//    If S < 2^W: p = ((2^W + S) << (kx+ky)) >> W.
//    Else:       p = (S << (kx+ky+1)) >> W.
//    Shifts are exact in 2N+W bits, then floor.
//  - If x == 0 or y == 0, p = 0. A zero flag travels down the pipe.
//  Pipeline: three stages, each with its own valid bit.
//  - S1 registers LOD results kx, ky, fx, fy and the zero flag.
//  - S2 registers k = kx+ky and S.
//  - S3 is the antilog shifter and drives p/out_valid.
//  - Latency is 3 cycles from the in_valid&&in_ready edge to out_valid with no stalls.
//  - Throughput is 1 pair per cycle.
//  Handshake:
//  - A transfer occurs on a rising edge where valid&&ready.
//  - Stage i loads when its valid is 0 or stage i+1 loads in the same edge (bubble collapsing).
//  - Stage 3 loads when !out_valid || out_ready.
//  - in_ready = !s1_valid || s1 loads; it is combinational from out_ready through the stage valids.
//  - While out_valid && !out_ready, p holds stable and no stage content is lost or duplicated.
//  - Stages not loading hold their data. Empty-stage data is don't-care, but p only changes on a stage-3 load.
//  Reset (async assert, sync release):
//  - All stage valids go to 0, out_valid = 0, p = 0, in_ready = 1 on the first cycle after release.
//  - Reset mid-stream discards all in-flight pairs; nothing is emitted afterwards for them.
//  Boundaries:
//  - Full pipe (3 valid) with out_ready = 0: in_ready = 0.
//  - out_ready rising while full: one result leaves and one pair may enter on the same edge.
//  - x or y equal to 1: k = 0, f = 0.
//  - Fraction bits below W are discarded (truncation, not rounding).
// CONFIGURATION
//  ELM_LSB_SET_EN:
//  - When defined, after truncation the LSB of fx and fy is forced to 1 for non-zero operands
//    (error-compensated ELM variant). The zero rule is unchanged.
//  - When undefined, plain truncation applies.
//  - Latency and ports are identical in both builds.
// TESTING (N=16, W=6)
//  1 x=256,y=256, out_ready=1
//    -> p=65536 exactly 3 cycles later (undefined macro).
//    -> p=67584 with ELM_LSB_SET_EN.
//  2 x=65535,y=65535
//    -> p=32'hFC00_0000 (undefined).
//    -> with ELM_LSB_SET_EN, fx=fy=63/64 is unchanged, so p=32'hFC00_0000.
//  3 x=0,y=12345 then x=3,y=3 back-to-back
//    -> p=0, then p=8, on consecutive cycles.
//  4 stream 6 pairs with out_ready=0 for 5 cycles:
//    -> in_ready drops after 3 accepted pairs and p holds the first result.
//    -> after release, all 6 results emerge in order, none lost or duplicated.
//  5 assert rst while 3 pairs are in flight:
//    -> out_valid=0 and p=0 immediately.
//    -> no stale result appears after release.
//  6 random 10k pairs with random out_ready:
//    -> every output matches a bit-exact model of the formula above.
//    -> output order equals input order.

Source files
------------

// File: rtl/mitch_log_mult_pipe_if.sv
// Streaming bundle for mitch_log_mult_pipe: operand-pair input channel and
// product output channel, both valid/ready.
//   master : the side that feeds operands and consumes products
//   slave  : the multiplier itself
interface mitch_log_mult_pipe_if #(
  parameter int N = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   x;
  logic [N-1:0]   y;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] p;

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, p
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, p
  );
endinterface

// File: rtl/mitch_log_mult_pipe.sv
// mitch_log_mult_pipe: three-stage Mitchell approximate logarithmic multiplier,
// unsigned NxN -> 2N, fractions truncated to W bits after leading-one detection.
// Stage p0 holds leading-one results, p1 the log-domain sum, p2 the antilog
// product. Each stage has its own valid; a stage loads when it is empty or its
// successor loads on the same edge, so bubbles collapse and a full pipe still
// moves one item per cycle.
// Build option: define ELM_LSB_SET_EN to force the LSB of each non-zero
// operand's truncated fraction to 1 (error-compensated ELM variant).
module mitch_log_mult_pipe #(
  parameter int N = 16,
  parameter int W = 6
) (
  input logic                  clk,
  input logic                  rst,
  mitch_log_mult_pipe_if.slave bus
);

  localparam int KW = $clog2(N);
  localparam int SW = KW + 1;

  // Position of the most significant set bit (0 for an all-zero operand).
  function automatic logic [KW-1:0] lod_k(input logic [N-1:0] v);
    logic [KW-1:0] k;
    k = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) k = KW'(i);
    end
    return k;
  endfunction

  // Bits below the leading one, left-aligned, top W kept (truncation).
  function automatic logic [W-1:0] lod_f(input logic [N-1:0] v, input logic [KW-1:0] k);
    logic [W-1:0] f;
    f = W'((v << (KW'(N - 1) - k)) >> (N - 1 - W));
`ifdef ELM_LSB_SET_EN
    if (v != '0) f[0] = 1'b1;
`endif
    return f;
  endfunction

  // Antilog: mantissa 1.S (or S with one extra shift on carry), shifted by
  // k and floored back by W fraction bits; zero operands force 0.
  function automatic logic [2*N-1:0] antilog(input logic [W:0] s,
                                              input logic [SW-1:0] k,
                                              input logic zero);
    logic [W:0]       mant;
    logic [SW-1:0]    sh;
    logic [2*N+W-1:0] wide;
    mant = s[W] ? s : {1'b1, s[W-1:0]};
    sh   = s[W] ? k + SW'(1) : k;
    wide = {{(2*N-1){1'b0}}, mant} << sh;
    return zero ? '0 : (2*N)'(wide >> W);
  endfunction

  logic vld_p0, vld_p1, vld_p2;
  logic ld_p0, ld_p1, ld_p2;

  logic [KW-1:0]  kx_p0, ky_p0;
  logic [W-1:0]   fx_p0, fy_p0;
  logic           zero_p0;
  logic [SW-1:0]  k_p1;
  logic [W:0]     s_p1;
  logic           zero_p1;
  logic [2*N-1:0] p_p2;

  // Load enables ripple back from the output so a draining pipe accepts input.
  always_comb begin
    ld_p2 = !vld_p2 || bus.out_ready;
    ld_p1 = !vld_p1 || ld_p2;
    ld_p0 = !vld_p0 || ld_p1;
  end

  assign bus.in_ready  = ld_p0;
  assign bus.out_valid = vld_p2;
  assign bus.p         = p_p2;

  // Stage valids advance with their load enables; reset empties the pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (ld_p0) vld_p0 <= bus.in_valid;
      if (ld_p1) vld_p1 <= vld_p0;
      if (ld_p2) vld_p2 <= vld_p1;
    end
  end

  // ---- stage p0: leading-one detection and fraction truncation ----
  // Captures LOD results when a new pair is accepted.
  always_ff @(posedge clk) begin
    if (ld_p0 && bus.in_valid) begin
      kx_p0   <= lod_k(bus.x);
      ky_p0   <= lod_k(bus.y);
      fx_p0   <= lod_f(bus.x, lod_k(bus.x));
      fy_p0   <= lod_f(bus.y, lod_k(bus.y));
      zero_p0 <= (bus.x == '0) || (bus.y == '0);
    end
  end

  // ---- stage p1: log-domain addition ----
  // Adds characteristics and fractions when stage p0 hands over an item.
  always_ff @(posedge clk) begin
    if (ld_p1 && vld_p0) begin
      k_p1    <= {1'b0, kx_p0} + {1'b0, ky_p0};
      s_p1    <= {1'b0, fx_p0} + {1'b0, fy_p0};
      zero_p1 <= zero_p0;
    end
  end

  // ---- stage p2: antilog shifter, drives the output ----
  // Product only changes when a real item moves in, so it holds under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_p2 <= '0;
    end else if (ld_p2 && vld_p1) begin
      p_p2 <= antilog(s_p1, k_p1, zero_p1);
    end
  end

endmodule
